pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Program-counter stage directly upstream of SingleCPU: owns the PC register that drives
//   SingleCPU.Addr_in and consumes SingleCPU.Addr_o as the next PC. Replaces open-loop
//   bench feedback with a clocked run/stall/halt sequencer. Counts retired instructions
//   and stops on a misaligned target, a self-loop (PC == next PC) or an instruction limit.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded at reset and on every (re)start
//   MAX_INSTR  23             retire limit that triggers halt; 0 disables the limit
//   CNT_W      16             width of the retired-instruction counter
// PORTS
//   clk          in   1      single clock; all state updates on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   start        in   1      1-cycle pulse: start from IDLE, restart from HALT
//   stall        in   1      1 = freeze PC, counter and halt checks this cycle
//   next_addr_i  in   32     next PC from SingleCPU.Addr_o
//   addr_o       out  32     current PC to SingleCPU.Addr_in (registered)
//   running      out  1      1 while in RUN (registered)
//   halted       out  1      1 while in HALT (registered)
//   halt_cause   out  2      00 NONE, 01 MISALIGN, 10 SELFLOOP, 11 LIMIT
//   retired_cnt  out  CNT_W  instructions retired since last start; saturates at all-ones
// BEHAVIOUR
//   Reset (rst_n=0, async): addr_o=RESET_PC, state=IDLE, running=0, halted=0,
//     halt_cause=00, retired_cnt=0. Release is synchronous to clk.
//   States: IDLE, RUN, HALT. running=(state==RUN), halted=(state==HALT).
//   IDLE: all outputs held. start=1 -> RUN; addr_o<=RESET_PC, retired_cnt<=0, cause<=00.
//     The instruction at RESET_PC executes during the first RUN cycle.
//   RUN, stall=1: nothing changes; halt checks not evaluated; start ignored.
//   RUN, stall=0: the current instruction retires: retired_cnt<=retired_cnt+1 (saturating).
//     Halt checks, highest priority first:
//     1 MISALIGN: next_addr_i[1:0]!=0 -> HALT, cause 01, addr_o held.
//     2 SELFLOOP: next_addr_i==addr_o -> HALT, cause 10, addr_o held.
//     3 LIMIT: MAX_INSTR!=0 and retired_cnt+1==MAX_INSTR -> HALT, cause 11,
//       addr_o<=next_addr_i.
//     otherwise: addr_o<=next_addr_i, stay in RUN.
//   RUN, start=1: ignored (no restart while running).
//   HALT: all outputs held. start=1 -> RUN with addr_o<=RESET_PC, retired_cnt<=0,
//     cause<=00 (halted drops and running rises on the same edge).
//   Latency: next_addr_i sampled at edge N appears on addr_o after edge N; one PC per
//     unstalled cycle. stall has priority over start only in RUN; in IDLE/HALT stall
//     is don't-care.
//   Limit compare uses CNT_W-bit arithmetic; MAX_INSTR must fit in CNT_W bits. If the
//     counter saturates, the LIMIT check stays false.
//   Reset mid-RUN: immediate return to reset values; no partial update survives.
//   next_addr_i is assumed combinational from addr_o; no X-propagation from it in IDLE/HALT.
// STRUCTURE
//   Shared package cpu_pkg: state typedef {IDLE,RUN,HALT}, halt_cause typedef and its
//     2-bit codes, RESET_PC default constant, word-alignment mask constant.
//   One sub-module is natural: pc_halt_check (combinational; inputs addr_o, next_addr_i,
//     retired_cnt; outputs halt request + cause, priority encoded as above).
//   Top-level pc_sequencer holds FSM, PC register and counter.
// TESTING
//   1 Reset: rst_n=0 mid-run -> addr_o=0, running=0, halted=0, cause=00, cnt=0 same cycle.
//   2 Linear run: start, next_addr_i=addr_o+4 -> addr_o 0,4,8,... one per edge; halt at
//     addr_o=0x5C, cnt=23, cause=11.
//   3 Stall: stall=1 for 3 cycles at addr_o=0x10 -> addr_o=0x10, cnt unchanged; resumes 0x14.
//   4 Self-loop: next_addr_i=addr_o at 0x20 -> HALT, cause=10, addr_o=0x20, cnt incremented.
//   5 Misaligned: next_addr_i=0x32 while MISALIGN and LIMIT coincide -> cause=01, addr_o held.
//   6 Restart: start in HALT -> addr_o=0, cnt=0, cause=00, running=1 next edge; start in RUN
//     ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter stage in front of SingleCPU.
// Provides the sequencer state encoding, the halt-cause codes reported on
// halt_cause, the default reset PC and the word-alignment mask.
package cpu_pkg;

    // Sequencer states, kept as plain 2-bit constants.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HALT = 2'd2;

    // Why the sequencer stopped; NONE after reset or (re)start.
    typedef logic [1:0] halt_cause_t;
    localparam halt_cause_t CAUSE_NONE     = 2'b00;
    localparam halt_cause_t CAUSE_MISALIGN = 2'b01;
    localparam halt_cause_t CAUSE_SELFLOOP = 2'b10;
    localparam halt_cause_t CAUSE_LIMIT    = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are 32-bit words, so the two low address bits must be zero.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/pc_halt_check.sv
// Combinational halt detector for pc_sequencer.
// Decides whether retiring the current instruction should stop the sequencer
// and why, with MISALIGN over SELFLOOP over LIMIT.
// Ports:
//   addr        in   32     current PC
//   next_addr   in   32     PC proposed by the CPU for the next instruction
//   retired_cnt in   CNT_W  instructions retired so far (before this one)
//   halt_req    out  1      1 = stop after this instruction
//   cause       out  2      reason code, CAUSE_NONE when halt_req=0
module pc_halt_check
    import cpu_pkg::*;
#(
    parameter int MAX_INSTR = 23,
    parameter int CNT_W     = 16
) (
    input  logic [31:0]      addr,
    input  logic [31:0]      next_addr,
    input  logic [CNT_W-1:0] retired_cnt,
    output logic             halt_req,
    output halt_cause_t      cause
);

    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(MAX_INSTR);

    logic [CNT_W-1:0] cnt_inc;
    logic             misalign;
    logic             selfloop;
    logic             limit;

    assign cnt_inc  = retired_cnt + CNT_W'(1);
    assign misalign = |(next_addr & WORD_ALIGN_MASK);
    assign selfloop = (next_addr == addr);
    // A saturated counter can never reach the limit again, so the wrapped
    // increment must not be allowed to match.
    assign limit    = (MAX_INSTR != 0) && (retired_cnt != '1) && (cnt_inc == LIMIT_VAL);

    // NOTE: both outputs get a default before the priority chain so no path
    // leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        halt_req = 1'b0;
        cause    = CAUSE_NONE;
        if (misalign) begin
            halt_req = 1'b1;
            cause    = CAUSE_MISALIGN;
        end else if (selfloop) begin
            halt_req = 1'b1;
            cause    = CAUSE_SELFLOOP;
        end else if (limit) begin
            halt_req = 1'b1;
            cause    = CAUSE_LIMIT;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage directly upstream of SingleCPU.
// Owns the PC that feeds SingleCPU.Addr_in and takes SingleCPU.Addr_o as the
// next PC. A start pulse launches (or relaunches) execution from RESET_PC;
// stall freezes the stage; a misaligned target, a self-loop or the retire
// limit stops it and records why.
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      start from IDLE / restart from HALT (ignored in RUN)
//   stall        in   1      freeze PC, counter and halt checks while running
//   next_addr_i  in   32     next PC from SingleCPU.Addr_o
//   addr_o       out  32     current PC (registered)
//   running      out  1      1 while in RUN (registered)
//   halted       out  1      1 while in HALT (registered)
//   halt_cause   out  2      00 NONE, 01 MISALIGN, 10 SELFLOOP, 11 LIMIT
//   retired_cnt  out  CNT_W  instructions retired since last start, saturating
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MAX_INSTR = 23,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [31:0]      next_addr_i,
    output logic [31:0]      addr_o,
    output logic             running,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t           state;
    logic             halt_req;
    halt_cause_t      req_cause;
    logic [CNT_W-1:0] cnt_sat_inc;

    pc_halt_check #(
        .MAX_INSTR (MAX_INSTR),
        .CNT_W     (CNT_W)
    ) u_halt_check (
        .addr        (addr_o),
        .next_addr   (next_addr_i),
        .retired_cnt (retired_cnt),
        .halt_req    (halt_req),
        .cause       (req_cause)
    );

    assign cnt_sat_inc = (retired_cnt == '1) ? retired_cnt : retired_cnt + CNT_W'(1);

    // running/halted are flopped alongside state rather than decoded from it,
    // so they change on exactly the same edge as the state they mirror.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block is
    // irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr_o      <= RESET_PC;
            running     <= 1'b0;
            halted      <= 1'b0;
            halt_cause  <= CAUSE_NONE;
            retired_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    // start is deliberately ignored here; stall wins.
                    if (!stall) begin
                        retired_cnt <= cnt_sat_inc;
                        if (halt_req) begin
                            state      <= ST_HALT;
                            running    <= 1'b0;
                            halted     <= 1'b1;
                            halt_cause <= req_cause;
                            // A limit halt still commits the target; a bad
                            // target (misaligned or self-loop) is not taken.
                            if (req_cause == CAUSE_LIMIT) begin
                                addr_o <= next_addr_i;
                            end
                        end else begin
                            addr_o <= next_addr_i;
                        end
                    end
                end
                default: begin
                    // IDLE and HALT hold everything until a start pulse.
                    if (start) begin
                        state       <= ST_RUN;
                        running     <= 1'b1;
                        halted      <= 1'b0;
                        addr_o      <= RESET_PC;
                        retired_cnt <= '0;
                        halt_cause  <= CAUSE_NONE;
                    end
                end
            endcase
        end
    end

endmodule
